// File: rtl/dirty_wb_pkg.sv
// Shared types for the dirty/pending-write producer:
// entry states, default widths and the entry record.
package dirty_wb_pkg;

    localparam int REGADDRWIDTH_DEF = 4;
    localparam int DATAWIDTH_DEF    = 16;
    localparam int TAGWIDTH_DEF     = 2;

    typedef enum logic [1:0] {
        FREE    = 2'b00,
        WAITING = 2'b01,
        READY   = 2'b10
    } entryState_t;

    typedef struct packed {
        entryState_t                 state;
        logic [REGADDRWIDTH_DEF-1:0] dest;
        logic [DATAWIDTH_DEF-1:0]    data;
    } entry_t;

endpackage

// File: rtl/lowest_set_finder.sv
// Priority finder: index of the lowest set bit of vec,
// plus a flag saying whether any bit is set.
module lowest_set_finder #(
    parameter int WIDTH = 4,
    parameter int IDXW  = 2
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  index,
    output logic             found
);

    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IDXW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dirty_writeback_tracker.sv
// Tag allocator, out-of-order result buffer and writeback
// arbiter that drives the one-hot DirtyWrite pulse.
module dirty_writeback_tracker
    import dirty_wb_pkg::*;
#(
    parameter int REGADDRWIDTH = REGADDRWIDTH_DEF,
    parameter int DATAWIDTH    = DATAWIDTH_DEF,
    parameter int TAGWIDTH     = TAGWIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       sync_rst_n,
    input  logic                       clk_en,
    input  logic                       IssueValid,
    output logic                       IssueReady,
    input  logic [REGADDRWIDTH-1:0]    IssueDest,
    output logic [TAGWIDTH-1:0]        IssueTag,
    input  logic                       RespValid,
    input  logic [TAGWIDTH-1:0]        RespTag,
    input  logic [DATAWIDTH-1:0]       RespData,
    output logic                       WBValid,
    input  logic                       WBReady,
    output logic [REGADDRWIDTH-1:0]    WBDest,
    output logic [DATAWIDTH-1:0]       WBData,
    output logic [2**REGADDRWIDTH-1:0] DirtyWriteVector,
    output logic [TAGWIDTH:0]          PendingCount,
    output logic                       ProtocolError
);

    localparam int NUMENTRIES = 2 ** TAGWIDTH;
    localparam int NUMREGS    = 2 ** REGADDRWIDTH;

    typedef struct packed {
        entryState_t             state;
        logic [REGADDRWIDTH-1:0] dest;
        logic [DATAWIDTH-1:0]    data;
    } slot_t;

    slot_t slots     [NUMENTRIES];
    slot_t slotsNext [NUMENTRIES];

    logic [TAGWIDTH:0] pendingQ;
    logic [TAGWIDTH:0] pendingNext;
    logic              errQ;
    logic              errNext;

    logic [NUMENTRIES-1:0] freeVec;
    logic [NUMENTRIES-1:0] readyVec;
    logic [TAGWIDTH-1:0]   freeIdx;
    logic [TAGWIDTH-1:0]   readyIdx;
    logic                  freeFound;
    logic                  readyFound;

    logic issueFire;
    logic respFire;
    logic respHit;
    logic wbFire;

    always_comb begin
        for (int i = 0; i < NUMENTRIES; i++) begin
            freeVec[i]  = (slots[i].state == FREE);
            readyVec[i] = (slots[i].state == READY);
        end
    end

    lowest_set_finder #(
        .WIDTH (NUMENTRIES),
        .IDXW  (TAGWIDTH)
    ) freeFinder (
        .vec   (freeVec),
        .index (freeIdx),
        .found (freeFound)
    );

    lowest_set_finder #(
        .WIDTH (NUMENTRIES),
        .IDXW  (TAGWIDTH)
    ) readyFinder (
        .vec   (readyVec),
        .index (readyIdx),
        .found (readyFound)
    );

    assign issueFire = IssueValid & IssueReady;
    assign wbFire    = WBValid & WBReady;
    assign respFire  = RespValid & clk_en;
    assign respHit   = (slots[RespTag].state == WAITING);

    // Fires only happen with clk_en high, so next == current
    // whenever the pipeline is stalled.
    always_comb begin
        slotsNext   = slots;
        errNext     = errQ;
        pendingNext = pendingQ
                    + (TAGWIDTH + 1)'(issueFire)
                    - (TAGWIDTH + 1)'(wbFire);
        if (issueFire) begin
            slotsNext[freeIdx].state = WAITING;
            slotsNext[freeIdx].dest  = IssueDest;
        end
        if (respFire) begin
            if (respHit) begin
                slotsNext[RespTag].state = READY;
                slotsNext[RespTag].data  = RespData;
            end else begin
                errNext = 1'b1;
            end
        end
        if (wbFire) begin
            slotsNext[readyIdx].state = FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            for (int i = 0; i < NUMENTRIES; i++) begin
                slots[i].state <= FREE;
                slots[i].dest  <= '0;
                slots[i].data  <= '0;
            end
            pendingQ <= '0;
            errQ     <= 1'b0;
        end else begin
            for (int i = 0; i < NUMENTRIES; i++) begin
                slots[i] <= slotsNext[i];
            end
            pendingQ <= pendingNext;
            errQ     <= errNext;
        end
    end

    always_comb begin
        IssueReady    = clk_en & freeFound;
        IssueTag      = freeIdx;
        WBValid       = clk_en & readyFound;
        WBDest        = slots[readyIdx].dest;
        WBData        = slots[readyIdx].data;
        PendingCount  = pendingQ;
        ProtocolError = errQ;
        for (int i = 0; i < NUMREGS; i++) begin
            DirtyWriteVector[i] =
                wbFire && (WBDest == REGADDRWIDTH'(i));
        end
    end

endmodule

// File: tb/tb_dirty_writeback_tracker.sv
// Scoreboard bench: directed scenarios then random traffic,
// checked against a tag-table reference model.
module tb_dirty_writeback_tracker;

    localparam int RAW = 4;
    localparam int DW  = 16;
    localparam int TW  = 2;
    localparam int NE  = 4;
    localparam int NR  = 16;

    logic          clk = 1'b0;
    logic          sync_rst_n;
    logic          clk_en;
    logic          IssueValid;
    logic          IssueReady;
    logic [RAW-1:0] IssueDest;
    logic [TW-1:0] IssueTag;
    logic          RespValid;
    logic [TW-1:0] RespTag;
    logic [DW-1:0] RespData;
    logic          WBValid;
    logic          WBReady;
    logic [RAW-1:0] WBDest;
    logic [DW-1:0] WBData;
    logic [NR-1:0] DirtyWriteVector;
    logic [TW:0]   PendingCount;
    logic          ProtocolError;

    dirty_writeback_tracker #(
        .REGADDRWIDTH (RAW),
        .DATAWIDTH    (DW),
        .TAGWIDTH     (TW)
    ) dut (
        .clk              (clk),
        .sync_rst_n       (sync_rst_n),
        .clk_en           (clk_en),
        .IssueValid       (IssueValid),
        .IssueReady       (IssueReady),
        .IssueDest        (IssueDest),
        .IssueTag         (IssueTag),
        .RespValid        (RespValid),
        .RespTag          (RespTag),
        .RespData         (RespData),
        .WBValid          (WBValid),
        .WBReady          (WBReady),
        .WBDest           (WBDest),
        .WBData           (WBData),
        .DirtyWriteVector (DirtyWriteVector),
        .PendingCount     (PendingCount),
        .ProtocolError    (ProtocolError)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dest;
        int data;
        int vec;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    bit   chkEn  = 1'b0;

    // Model: 0 = unallocated, 1 = awaiting result, 2 = result held
    int mState [NE];
    int mDest  [NE];
    int mData  [NE];
    bit mErr;

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, req);
        end
    endtask

    task automatic step(bit rn, bit en, bit iv, int idest,
                        bit rv, int rtag, int rdata, bit wbr);
        int freeIdx;
        int readyIdx;
        int cnt;
        bit iRdy;
        bit wVal;
        bit iFire;
        bit wFire;
        int ns [NE];
        @(negedge clk);
        sync_rst_n = rn;
        clk_en     = en;
        IssueValid = iv;
        IssueDest  = RAW'(idest);
        RespValid  = rv;
        RespTag    = TW'(rtag);
        RespData   = DW'(rdata);
        WBReady    = wbr;
        #1;
        freeIdx  = -1;
        readyIdx = -1;
        cnt      = 0;
        for (int i = NE - 1; i >= 0; i--) begin
            if (mState[i] == 0) freeIdx = i;
            if (mState[i] == 2) readyIdx = i;
            if (mState[i] != 0) cnt++;
        end
        iRdy  = en && (freeIdx >= 0);
        wVal  = en && (readyIdx >= 0);
        iFire = iRdy && iv;
        wFire = wVal && wbr;
        if (chkEn) begin
            chk("IssueReady", IssueReady, iRdy);
            if (iRdy) chk("IssueTag", IssueTag, freeIdx);
            chk("WBValid", WBValid, wVal);
            if (wVal) begin
                chk("WBDest", WBDest, mDest[readyIdx]);
                chk("WBData", WBData, mData[readyIdx]);
            end
            chk("PendingCount", PendingCount, cnt);
            chk("ProtocolError", ProtocolError, mErr);
            chk("wbMissed", expQ.size(), 0);
            if (wFire)
                expQ.push_back('{mDest[readyIdx],
                                 mData[readyIdx],
                                 1 << mDest[readyIdx]});
            else
                chk("DirtyIdle", DirtyWriteVector, 0);
        end
        @(posedge clk);
        ns = mState;
        if (!rn) begin
            for (int i = 0; i < NE; i++) ns[i] = 0;
            mErr = 1'b0;
        end else if (en) begin
            if (rv) begin
                if (mState[rtag] == 1) begin
                    ns[rtag]    = 2;
                    mData[rtag] = rdata & 16'hFFFF;
                end else begin
                    mErr = 1'b1;
                end
            end
            if (iFire) begin
                ns[freeIdx]    = 1;
                mDest[freeIdx] = idest & 4'hF;
            end
            if (wFire) ns[readyIdx] = 0;
        end
        mState = ns;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (WBValid === 1'b1 && WBReady === 1'b1) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wbUnexpected dest=%0d",
                             WBDest);
                end else begin
                    e = expQ.pop_front();
                    chk("FireDest", WBDest, e.dest);
                    chk("FireData", WBData, e.data);
                    chk("DirtyVec", DirtyWriteVector, e.vec);
                end
            end
        end
    end

    function automatic int pickWaiting();
        int cand[$];
        for (int i = 0; i < NE; i++)
            if (mState[i] == 1) cand.push_back(i);
        if (cand.size() == 0) return $urandom_range(0, NE - 1);
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    initial begin
        for (int i = 0; i < NE; i++) begin
            mState[i] = 0;
            mDest[i]  = 0;
            mData[i]  = 0;
        end
        mErr = 1'b0;
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chkEn = 1'b1;
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        // round trip
        step(1, 1, 1, 5, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1, 0, 'hBEEF, 1);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        // fill, out-of-order completion
        for (int d = 1; d <= 4; d++) step(1, 1, 1, d, 0, 0, 0, 0);
        step(1, 1, 1, 9, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 3, 'h3333, 0);
        step(1, 1, 0, 0, 1, 1, 'h1111, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        // backpressure and stall
        step(1, 1, 0, 0, 1, 0, 'hA5A5, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 6, 1, 1, 'h7777, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1, 2, 'h2222, 1);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        // protocol error on a free entry
        step(1, 1, 0, 0, 1, 2, 'hDEAD, 0);
        for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
        // simultaneous issue, response, writeback
        step(1, 1, 1, 10, 0, 0, 0, 0);
        step(1, 1, 1, 11, 0, 0, 0, 0);
        step(1, 1, 1, 12, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 1, 'h0101, 0);
        step(1, 1, 0, 0, 1, 2, 'h0202, 1);
        step(1, 1, 1, 7, 1, 0, 'h0303, 1);
        step(1, 1, 1, 13, 0, 0, 0, 0);
        // reset with entries pending
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            bit rn;
            bit rv;
            int rtag;
            rn = ($urandom_range(0, 59) != 0);
            rv = ($urandom_range(0, 2) == 0);
            rtag = ($urandom_range(0, 9) != 0)
                 ? pickWaiting() : $urandom_range(0, NE - 1);
            step(rn, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 1), $urandom_range(0, NR - 1),
                 rv, rtag, $urandom_range(0, 65535),
                 $urandom_range(0, 3) != 0);
        end
        step(1, 1, 0, 0, 0, 0, 0, 0);
        #5;
        chk("wbDrained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dirty_writeback_tracker.md
Name: dirty_writeback_tracker

Overview:
- Producer side of the per-register dirty/pending-write scoreboard.
- Allocates a tag for each multicycle operation at issue and buffers its out-of-order completion data.
- Arbitrates buffered results onto the register-file writeback port.
- On each accepted writeback, emits the one-hot DirtyWrite pulse consumed by the per-register scoreboard state machines.

Parameters:
- REGADDRWIDTH, 4, register index width; register count is 2**REGADDRWIDTH.
- DATAWIDTH, 16, writeback data width.
- TAGWIDTH, 2, tag width; entry count is 2**TAGWIDTH.

Ports:
- clk  in  1  single clock, all state on rising edge.
- sync_rst_n  in  1  reset, synchronous and active-low.
- clk_en  in  1  global stall; low freezes all state and suppresses all handshake fires.
- IssueValid  in  1  multicycle op requests a tag.
- IssueReady  out  1  a FREE entry exists and clk_en is high.
- IssueDest  in  REGADDRWIDTH  destination register of the issuing op.
- IssueTag  out  TAGWIDTH  tag granted; valid while IssueReady is high.
- RespValid  in  1  multicycle unit returns a result; always accepted, no ready.
- RespTag  in  TAGWIDTH  tag of the returning result.
- RespData  in  DATAWIDTH  result data.
- WBValid  out  1  a READY entry is presented for writeback.
- WBReady  in  1  register-file write port is free this cycle.
- WBDest  out  REGADDRWIDTH  destination of the presented entry.
- WBData  out  DATAWIDTH  data of the presented entry.
- DirtyWriteVector  out  2**REGADDRWIDTH  one-hot pulse on bit WBDest when a writeback fires; otherwise zero.
- PendingCount  out  TAGWIDTH+1  number of non-FREE entries.
- ProtocolError  out  1  sticky error flag.

Behaviour:
- Each entry holds state, dest and data. States: FREE, WAITING, READY.
- Reset (sync_rst_n low at an edge):
  - All entries go FREE; ProtocolError clears.
  - Outputs after reset: WBValid=0, DirtyWriteVector=0, PendingCount=0, IssueReady=clk_en.
  - Reset mid-operation discards every entry silently.
- Fire definitions:
  - IssueFire = IssueValid && IssueReady.
  - RespFire = RespValid && clk_en.
  - WBFire = WBValid && WBReady.
  - All three require clk_en high.
- Issue:
  - IssueTag is the lowest-index FREE entry, combinational from registered state.
  - On IssueFire at cycle n, the entry becomes WAITING with IssueDest at n+1.
- Response:
  - RespFire with the RespTag entry WAITING: entry becomes READY with RespData at n+1.
  - RespFire with the RespTag entry FREE or READY: ProtocolError set at n+1; entry unchanged.
- Writeback:
  - WBValid is high when any entry is READY and clk_en is high.
  - The presented entry is the lowest-index READY entry; WBDest and WBData are combinational from it.
  - Latency: response at n, WBValid at n+1 at the earliest.
  - On WBFire at m, the entry becomes FREE at m+1. It cannot be reallocated in cycle m; IssueReady only reflects registered state.
- DirtyWriteVector = WBFire ? (1 << WBDest) : 0, combinational, same cycle as WBFire.
- A stalled writeback (WBReady low) holds WBDest and WBData stable unless a lower-index entry becomes READY. In that case the presented entry switches; this is permitted because there is no commitment before the fire.
- Simultaneous events:
  - Issue, response and writeback on distinct entries in one cycle all take effect.
  - A response to the entry currently firing writeback is an error, since that entry is READY.
- Full: all entries non-FREE, so IssueReady=0 and IssueTag is don't-care.
- Empty: PendingCount=0 and WBValid=0.
- PendingCount updates at n+1 by +IssueFire −WBFire; the result stays within 0..2**TAGWIDTH.
- clk_en low: IssueReady=0, WBValid=0, DirtyWriteVector=0; RespValid is ignored and no error is flagged.

Decomposition:
- Package dirty_wb_pkg holds:
  - entry state enum: FREE=2'b00, WAITING=2'b01, READY=2'b10;
  - the default width constants;
  - an entry struct {state, dest, data}.
- One sub-module, lowest_set_finder (parameterised width; outputs index and any-found). It is instantiated twice: FREE-entry allocation and READY-entry writeback selection.

Test Plan:
- Reset then idle: sync_rst_n low 2 cycles, clk_en=1 → IssueReady=1, IssueTag=0, WBValid=0, PendingCount=0, DirtyWriteVector=0.
- Basic round trip: issue dest=5, then RespTag=0 data=16'hBEEF, WBReady=1 → WBValid=1, WBDest=5, WBData=16'hBEEF, DirtyWriteVector=16'h0020 in that cycle; PendingCount returns to 0 the next cycle.
- Fill and out-of-order completion:
  - Issue dests 1,2,3,4 → tags 0..3, then IssueReady=0 and PendingCount=4.
  - Respond tags 3 then 1 with WBReady=0 → WBDest=2 (tag 1 takes priority).
  - Raise WBReady → writebacks go to dest 2 then dest 4.
- Backpressure and clk_en:
  - READY entry with WBReady=0 for 5 cycles → WBValid held and DirtyWriteVector=0 throughout.
  - Drop clk_en with WBReady=1 → no fire, PendingCount unchanged.
- Protocol error: RespTag=2 while entry 2 is FREE → ProtocolError=1 next cycle and stays set; entry 2 stays FREE; only reset clears the flag.
- Simultaneous events and reset mid-op:
  - Same cycle: issue dest=7 (tag 1), response on tag 0, writeback of tag 2 → all three take effect; PendingCount net 0.
  - Then reset with 3 entries pending → all FREE and PendingCount=0 next cycle.
